// File: rtl/rs_drv_pkg.sv
// Shared types and sizing helpers for the RS flip-flop command driver.
package rs_drv_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Width of a down-counter able to hold the longer of the two durations.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(1, 2);

endpackage

// File: rtl/rs_cmd_driver_if.sv
// Request handshake between a command source and rs_cmd_driver.
interface rs_cmd_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req_valid;
  logic [WIDTH-1:0] req_level;
  logic             req_ready;

  modport master (output req_valid, output req_level, input req_ready);
  modport slave  (input req_valid, input req_level, output req_ready);
endinterface

// File: rtl/rs_pulse_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded duration.
module rs_pulse_timer #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned RST_VAL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  // Reload on state entry, otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_W'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count <= CNT_W'(1));

endmodule

// File: rtl/rs_cmd_driver.sv
// Command driver for a bank of clocked RS flip-flops.
// Optional feedback check enabled by defining RS_VERIFY_EN.
module rs_cmd_driver
  import rs_drv_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic             clk,
  input  logic             rst,
  rs_cmd_driver_if.slave   req,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q_track,
  input  logic [WIDTH-1:0] q_fb,
  output logic             err
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  state_t           state, state_nx;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] set_v, clr_v;
  logic [WIDTH-1:0] s_nx, r_nx;
  logic             ready, ready_nx;
  logic             accept;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             done;

  rs_pulse_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (HOLD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .done     (done)
  );

  assign req.req_ready = ready;
  assign accept        = req.req_valid && ready;
  assign set_v         = req.req_level & ~q_track;
  assign clr_v         = ~req.req_level & q_track;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  // Next state and the registered output values for the cycle being entered.
  always_comb begin
    state_nx = state;
    s_nx     = '0;
    r_nx     = '0;
    ready_nx = 1'b0;
    load     = 1'b0;
    load_val = CNT_W'(GAP_CYCLES);
    unique case (state)
      INIT: begin
        // The cycle right after reset still shows r=0 (its reset value);
        // r[0] low marks that cycle, so the HOLD count restarts from there.
        if (!r[0]) begin
          r_nx     = '1;
          load     = 1'b1;
          load_val = CNT_W'(HOLD_CYCLES);
        end else if (done) begin
          state_nx = GAP;
          load     = 1'b1;
          load_val = CNT_W'(GAP_CYCLES);
        end else begin
          r_nx = '1;
        end
      end
      IDLE: begin
        ready_nx = 1'b1;
        if (accept && ((set_v | clr_v) != '0)) begin
          state_nx = PULSE;
          s_nx     = set_v;
          r_nx     = clr_v;
          ready_nx = 1'b0;
          load     = 1'b1;
          load_val = CNT_W'(HOLD_CYCLES);
        end
      end
      PULSE: begin
        if (done) begin
          state_nx = GAP;
          load     = 1'b1;
          load_val = CNT_W'(GAP_CYCLES);
        end else begin
          s_nx = s;
          r_nx = r;
        end
      end
      GAP: begin
        if (done) begin
          state_nx = IDLE;
          ready_nx = 1'b1;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  // Registered pulse and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s     <= '0;
      r     <= '0;
      ready <= 1'b0;
    end else begin
      s     <= s_nx;
      r     <= r_nx;
      ready <= ready_nx;
    end
  end

  // Capture the target at accept; publish it as the tracked level when the pulse ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= '0;
      q_track <= '0;
    end else begin
      if (accept) cap <= req.req_level;
      if (state == PULSE && done) q_track <= cap;
    end
  end

`ifdef RS_VERIFY_EN
  // Sticky feedback check in the first GAP cycle, once the flip-flops have settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == GAP && count == CNT_W'(GAP_CYCLES) && q_fb != q_track) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = ^{q_fb, count};
  assign err       = 1'b0;
`endif

endmodule
